// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - instruction-fetch handshake between control FSM and fetch unit
//   instr       : instruction word from the fetch unit
//   instr_valid : instr holds a valid fetched word
//   fetch_req   : control requests an instruction
//   ir_load     : control captures instr into its IR this cycle
interface multicycle_control_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_req;
  logic        ir_load;

  modport master (input instr, input instr_valid, output fetch_req, output ir_load);
  modport slave  (output instr, output instr_valid, input fetch_req, input ir_load);
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM (fetch/decode/exec/mem/wb)
//   clk, rst_n      : clock, asynchronous active-low reset
//   fetch_if        : fetch handshake (instr, instr_valid in; fetch_req, ir_load out)
//   vreg, zero      : $v0 for syscalls, ALU zero flag for branches
//   pc_write/pc_src : PC update strobe and source select
//   RegDst..alu_op  : datapath controls
//   print_req, illegal, halted : syscall print, unsupported-instruction pulse, sticky halt
module multicycle_control #(
  parameter int ALUOP_W   = 3,
  parameter int MEM_WAIT  = 2,
  parameter int SYS_PRINT = 4,
  parameter int SYS_EXIT  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master fetch_if,
  input  logic [31:0]         vreg,
  input  logic                zero,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                RegDst,
  output logic                link,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemToReg,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                print_req,
  output logic                illegal,
  output logic                halted
);

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09,
                         OP_SLTIU = 6'h0B, OP_ORI = 6'h0D, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ADD = 6'h20,
                         FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'b111);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_SYSCALL, S_HALT
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     ir;
  logic [CW-1:0]   cnt;

  logic [5:0] op, fn;
  logic is_r, r_alu, i_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_sys;
  logic [ALUOP_W-1:0] alu_sel;
  logic ir_unused;

  // Register fields are consumed by the datapath, not by control.
  assign ir_unused = ^ir[25:6];

  assign op     = ir[31:26];
  assign fn     = ir[5:0];
  assign is_r   = (op == OP_R);
  assign r_alu  = is_r && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
  assign i_alu  = op inside {OP_ADDI, OP_ADDIU, OP_SLTIU, OP_ORI, OP_LUI};
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);
  assign is_jr  = is_r && (fn == FN_JR);
  assign is_sys = is_r && (fn == FN_SYSCALL);

  always_comb begin
    alu_sel = ALU_ADD;
    if (is_r) begin
      case (fn)
        FN_SUB:  alu_sel = ALU_SUB;
        FN_AND:  alu_sel = ALU_AND;
        FN_OR:   alu_sel = ALU_OR;
        FN_SLT:  alu_sel = ALU_SLT;
        default: alu_sel = ALU_ADD;
      endcase
    end else if (op == OP_ORI) begin
      alu_sel = ALU_OR;
    end else if (op == OP_SLTIU) begin
      alu_sel = ALU_SLT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_if.ir_load) ir <= fetch_if.instr;
      // Counter is armed on the EXEC->MEM edge so MEM lasts exactly MEM_WAIT cycles.
      if (state == S_EXEC && state_nxt == S_MEM) cnt <= CW'(MEM_WAIT - 1);
      else if (state == S_MEM && cnt != '0) cnt <= cnt - CW'(1);
    end
  end

  always_comb begin
    state_nxt          = state;
    fetch_if.fetch_req = 1'b0;
    fetch_if.ir_load   = 1'b0;
    pc_write           = 1'b0;
    pc_src             = 2'b00;
    RegDst             = 1'b0;
    link               = 1'b0;
    MemRead            = 1'b0;
    MemWrite           = 1'b0;
    MemToReg           = 1'b0;
    RegWrite           = 1'b0;
    ALUSrc             = 1'b0;
    alu_op             = '0;
    print_req          = 1'b0;
    illegal            = 1'b0;
    halted             = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        fetch_if.fetch_req = 1'b1;
        if (fetch_if.instr_valid) begin
          fetch_if.ir_load = 1'b1;
          state_nxt        = S_DECODE;
        end
      end
      S_DECODE: begin
        if (r_alu || i_alu || is_lw || is_sw) state_nxt = S_EXEC;
        else if (is_beq || is_bne)            state_nxt = S_BRANCH;
        else if (is_j || is_jal || is_jr)     state_nxt = S_JUMP;
        else if (is_sys)                      state_nxt = S_SYSCALL;
        else begin
          illegal   = 1'b1;
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op    = alu_sel;
        ALUSrc    = i_alu || is_lw || is_sw;
        state_nxt = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        MemRead  = is_lw;
        MemWrite = is_sw;
        if (cnt == '0) begin
          if (is_lw) state_nxt = S_WB;
          else begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        RegDst    = r_alu;
        MemToReg  = is_lw;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        alu_op    = ALU_SUB;
        pc_write  = 1'b1;
        pc_src    = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
        state_nxt = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = is_jr ? 2'b11 : 2'b10;
        RegWrite  = is_jal;
        link      = is_jal;
        state_nxt = S_FETCH;
      end
      S_SYSCALL: begin
        if (vreg == 32'(SYS_EXIT)) begin
          state_nxt = S_HALT;
        end else begin
          print_req = (vreg == 32'(SYS_PRINT));
          illegal   = (vreg != 32'(SYS_PRINT));
          pc_write  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] vreg;
  logic zero;
  logic pc_write, RegDst, link, MemRead, MemWrite, MemToReg, RegWrite, ALUSrc;
  logic print_req, illegal, halted;
  logic [1:0] pc_src;
  logic [2:0] alu_op;
  logic [17:0] all_outs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_control_if fetch_bus ();

  multicycle_control #(.MEM_WAIT(W)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_if(fetch_bus), .vreg(vreg), .zero(zero),
    .pc_write(pc_write), .pc_src(pc_src), .RegDst(RegDst), .link(link),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrc(ALUSrc), .alu_op(alu_op), .print_req(print_req), .illegal(illegal),
    .halted(halted)
  );

  assign all_outs = {fetch_bus.fetch_req, fetch_bus.ir_load, pc_write, pc_src, RegDst, link,
                     MemRead, MemWrite, MemToReg, RegWrite, ALUSrc, alu_op, print_req,
                     illegal, halted};

  typedef struct {
    int cycles, fetch, irld, pcw, pc_src, memrd, memwr, regwr, regdst, m2r, link,
        print, illegal, alusrc, alu, halted;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] v;
    logic        z;
    int          lat, src, rw, ill, mem;
  } tv_t;

  tv_t tbl[$];
  logic [31:0] pool [0:13];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level expectation for one instruction, from the ISA rules.
  function automatic obs_t model(input logic [31:0] ins, input logic [31:0] v, input logic z,
                                 input int dly);
    obs_t e;
    logic [5:0] op, fn;
    e = '{default: 0};
    op = ins[31:26];
    fn = ins[5:0];
    e.fetch = 1 + dly; e.irld = 1; e.pcw = 1; e.cycles = 2; e.illegal = 1;
    if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A})) begin
      e.illegal = 0; e.cycles = 4; e.regwr = 1; e.regdst = 1;
      e.alu = (fn == 6'h22) ? 6 : (fn == 6'h24) ? 0 : (fn == 6'h25) ? 1 : (fn == 6'h2A) ? 7 : 2;
    end else if (op inside {6'h08, 6'h09, 6'h0B, 6'h0D, 6'h0F}) begin
      e.illegal = 0; e.cycles = 4; e.regwr = 1; e.alusrc = 1;
      e.alu = (op == 6'h0D) ? 1 : (op == 6'h0B) ? 7 : 2;
    end else if (op == 6'h23) begin
      e.illegal = 0; e.cycles = 4 + W; e.regwr = 1; e.m2r = 1; e.memrd = W; e.alusrc = 1; e.alu = 2;
    end else if (op == 6'h2B) begin
      e.illegal = 0; e.cycles = 3 + W; e.memwr = W; e.alusrc = 1; e.alu = 2;
    end else if (op == 6'h04 || op == 6'h05) begin
      e.illegal = 0; e.cycles = 3; e.alu = 6;
      e.pc_src = ((op == 6'h04) == (z == 1'b1)) ? 1 : 0;
    end else if (op == 6'h02 || op == 6'h03) begin
      e.illegal = 0; e.cycles = 3; e.pc_src = 2;
      e.regwr = (op == 6'h03) ? 1 : 0; e.link = e.regwr;
    end else if (op == 6'h00 && fn == 6'h08) begin
      e.illegal = 0; e.cycles = 3; e.pc_src = 3;
    end else if (op == 6'h00 && fn == 6'h0C) begin
      e.cycles = 3;
      if (v == 32'd10) begin
        e.illegal = 0; e.cycles = 4; e.pcw = 0; e.halted = 1;
      end else if (v == 32'd4) begin
        e.illegal = 0; e.print = 1;
      end
    end
    e.cycles += dly;
    return e;
  endfunction

  // Entered one cycle before FETCH; ends after the pc_write (or halted) cycle is sampled.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] v, input logic z,
                           input int dly, output obs_t o);
    bit done;
    o = '{default: 0};
    done = 1'b0;
    @(posedge clk); #1;
    fetch_bus.instr = ins; fetch_bus.instr_valid = (dly == 0); vreg = v; zero = z;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
        if (c == dly + 1) fetch_bus.instr_valid = 1'b1;
      end
      #1;
      o.cycles = c;
      o.fetch  += int'(fetch_bus.fetch_req);
      o.irld   += int'(fetch_bus.ir_load);
      o.memrd  += int'(MemRead);
      o.memwr  += int'(MemWrite);
      o.regwr  += int'(RegWrite);
      o.regdst += int'(RegDst);
      o.m2r    += int'(MemToReg);
      o.link   += int'(link);
      o.print  += int'(print_req);
      o.illegal += int'(illegal);
      o.alusrc += int'(ALUSrc);
      o.alu    |= int'(alu_op);
      o.halted += int'(halted);
      if (pc_write) begin
        o.pcw++;
        o.pc_src = int'(pc_src);
      end
      if (pc_write || halted) done = 1'b1;
    end
    if (!done) o.cycles = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_bus.instr_valid = 1'b0;
    #1 check("reset_outs", int'(all_outs), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("idle_outs", int'(all_outs), 0);
  endtask

  task automatic cmp_obs(input string t, input obs_t a, input obs_t e);
    check({t, ".cycles"}, a.cycles, e.cycles);
    check({t, ".fetch"}, a.fetch, e.fetch);
    check({t, ".ir_load"}, a.irld, e.irld);
    check({t, ".pc_write"}, a.pcw, e.pcw);
    check({t, ".pc_src"}, a.pc_src, e.pc_src);
    check({t, ".MemRead"}, a.memrd, e.memrd);
    check({t, ".MemWrite"}, a.memwr, e.memwr);
    check({t, ".RegWrite"}, a.regwr, e.regwr);
    check({t, ".RegDst"}, a.regdst, e.regdst);
    check({t, ".MemToReg"}, a.m2r, e.m2r);
    check({t, ".link"}, a.link, e.link);
    check({t, ".print_req"}, a.print, e.print);
    check({t, ".illegal"}, a.illegal, e.illegal);
    check({t, ".ALUSrc"}, a.alusrc, e.alusrc);
    check({t, ".alu_op"}, a.alu, e.alu);
    check({t, ".halted"}, a.halted, e.halted);
  endtask

  task automatic apply(input string t, input logic [31:0] ins, input logic [31:0] v,
                       input logic z, input int dly, output obs_t o);
    run_instr(ins, v, z, dly, o);
    cmp_obs(t, o, model(ins, v, z, dly));
    if (o.cycles < 0) do_reset();
  endtask

  initial begin
    obs_t o;
    logic [31:0] ins, v;
    vreg = '0; zero = 1'b0; fetch_bus.instr = '0; fetch_bus.instr_valid = 1'b0;

    //          ins           vreg   z     lat    src rw ill mem
    tbl.push_back('{32'h00221820, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h8C080004, 32'd0, 1'b0, 4 + W, 0, 1, 0, W});
    tbl.push_back('{32'hAC080004, 32'd0, 1'b0, 3 + W, 0, 0, 0, W});
    tbl.push_back('{32'h10000003, 32'd0, 1'b1, 3,     1, 0, 0, 0});
    tbl.push_back('{32'h10000003, 32'd0, 1'b0, 3,     0, 0, 0, 0});
    tbl.push_back('{32'h14000003, 32'd0, 1'b0, 3,     1, 0, 0, 0});
    tbl.push_back('{32'h14000003, 32'd0, 1'b1, 3,     0, 0, 0, 0});
    tbl.push_back('{32'h0C000010, 32'd0, 1'b0, 3,     2, 1, 0, 0});
    tbl.push_back('{32'h03E00008, 32'd0, 1'b0, 3,     3, 0, 0, 0});
    tbl.push_back('{32'h08000010, 32'd0, 1'b0, 3,     2, 0, 0, 0});
    tbl.push_back('{32'h0000000C, 32'd4, 1'b0, 3,     0, 0, 0, 0});
    tbl.push_back('{32'h0000000C, 32'd7, 1'b0, 3,     0, 0, 1, 0});
    tbl.push_back('{32'hFC000000, 32'd0, 1'b0, 2,     0, 0, 1, 0});
    tbl.push_back('{32'h00221821, 32'd0, 1'b0, 2,     0, 0, 1, 0});
    tbl.push_back('{32'h3C011234, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h34210001, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h2C21000F, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h0022182A, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h00221822, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h00221824, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h00221825, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h20210001, 32'd0, 1'b0, 4,     0, 1, 0, 0});
    tbl.push_back('{32'h24210001, 32'd0, 1'b0, 4,     0, 1, 0, 0});

    pool = '{32'h00000020, 32'h00000022, 32'h00000024, 32'h00000025, 32'h0000002A,
             32'h00000008, 32'h0000000C, 32'h20000000, 32'h34000000, 32'h8C000000,
             32'hAC000000, 32'h10000000, 32'h14000000, 32'h0C000000};

    do_reset();

    // Fetch stall: valid low for 5 cycles in FETCH.
    apply("add_stall", 32'h00221820, 32'd0, 1'b0, 5, o);
    check("add_stall.fetch_cycles", o.fetch, 6);

    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      apply(t, tbl[i].ins, tbl[i].v, tbl[i].z, 0, o);
      check({t, ".lat"}, o.cycles, tbl[i].lat);
      check({t, ".src"}, o.pc_src, tbl[i].src);
      check({t, ".rw"}, o.regwr, tbl[i].rw);
      check({t, ".ill"}, o.illegal, tbl[i].ill);
      check({t, ".mem"}, o.memrd + o.memwr, tbl[i].mem);
    end

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) ins = $urandom;
      else begin
        ins = pool[$urandom_range(0, 13)];
        if (ins[31:26] == 6'h00) ins = ins | ($urandom & 32'h03FFFFC0);
        else ins = ins | ($urandom & 32'h03FFFFFF);
      end
      case ($urandom_range(0, 2))
        0: v = 32'd4;
        1: v = 32'd7;
        default: v = $urandom;
      endcase
      if (v == 32'd10) v = 32'd11;
      apply($sformatf("rnd%0d", n), ins, v, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2)), o);
    end

    // Reset asserted in the middle of SW's MEM phase.
    @(posedge clk); #1;
    fetch_bus.instr = 32'hAC080004; fetch_bus.instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("sw_mid_memwrite", int'(MemWrite), 1);
    check("sw_mid_pcwrite", int'(pc_write), 0);
    #1 rst_n = 1'b0;
    #1 check("sw_rst_outs", int'(all_outs), 0);
    repeat (2) begin
      @(posedge clk);
      #2 check("sw_rst_hold", int'(all_outs), 0);
    end
    #1 rst_n = 1'b1;
    #1 check("sw_rst_idle", int'(all_outs), 0);
    apply("after_rst_add", 32'h00221820, 32'd0, 1'b0, 0, o);

    // Exit syscall: halted is sticky and fetch stops even with valid held high.
    apply("sys_exit", 32'h0000000C, 32'd10, 1'b0, 0, o);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2 check($sformatf("halt_hold%0d", k),
               int'({halted, fetch_bus.fetch_req, pc_write, fetch_bus.ir_load}), 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Successor to the combinational MIPS decoder: a multicycle control FSM that sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives the same datapath control set, plus PC-update, fetch handshake, memory wait-state and syscall/halt control.
- Sits between the instruction-fetch interface and the single shared-ALU datapath.

Parameters:
- ALUOP_W, 3, width of alu_op. Codes are zero-extended: and=000, or=001, add=010, sub=110, slt=111.
- MEM_WAIT, 2, number of cycles the MEM state holds MemRead/MemWrite. Must be ≥1.
- SYS_PRINT, 4, vreg value that requests a print.
- SYS_EXIT, 10, vreg value that halts the core.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word; latched into the internal IR when ir_load=1.
- instr_valid  in  1  fetch data valid.
- vreg  in  32  $v0 contents, sampled in SYSCALL.
- zero  in  1  ALU zero flag, sampled in BRANCH.
- fetch_req  out  1  instruction fetch request.
- ir_load  out  1  IR capture strobe.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  PC source: 00=PC+4, 01=branch target, 10=jump target, 11=rs (JR).
- RegDst  out  1  destination register is rd.
- link  out  1  write $31 with PC+4 (JAL).
- MemRead  out  1  data memory read.
- MemWrite  out  1  data memory write.
- MemToReg  out  1  write-back data comes from memory.
- RegWrite  out  1  register file write.
- ALUSrc  out  1  ALU B operand is the immediate.
- alu_op  out  ALUOP_W  ALU operation.
- print_req  out  1  one-cycle print request (syscall 4).
- illegal  out  1  one-cycle pulse on an unsupported opcode, funct or syscall.
- halted  out  1  core halted; sticky until reset.

Behaviour:
- Outputs are a Moore decode of state plus the latched IR. In states not listed, every output is 0.
- Reset (rst_n low, at any time, including mid-MEM): state=IDLE, IR=0, wait counter=0, all outputs 0. The in-flight instruction is abandoned and no strobe is issued.
- IDLE: moves to FETCH on the first clock after rst_n goes high.
- FETCH:
  - fetch_req=1. Holds while instr_valid=0.
  - When instr_valid=1: ir_load=1 in the same cycle, next state DECODE.
- DECODE: decodes the IR opcode/funct.
  - R-type ADD/SUB/AND/OR/SLT, ADDI/ADDIU/ORI/SLTIU/LUI, LW, SW -> EXEC.
  - BEQ/BNE -> BRANCH.
  - J/JAL/JR -> JUMP.
  - SYSCALL -> SYSCALL.
  - Anything else: illegal=1, pc_write=1, pc_src=00, next state FETCH.
- EXEC:
  - alu_op per instruction: ADD/ADDI/ADDIU/LW/SW/LUI=add, SUB=sub, AND=and, OR/ORI=or, SLT/SLTIU=slt.
  - ALUSrc=1 for I-type.
  - LW/SW -> MEM; all others -> WB.
- MEM:
  - Wait counter loads MEM_WAIT-1 on entry and decrements each cycle. MemRead (LW) or MemWrite (SW) is held the whole time.
  - When the counter reaches 0: LW -> WB. SW asserts pc_write=1, pc_src=00 in that cycle, then -> FETCH.
- WB:
  - RegWrite=1, RegDst=1 for R-type, MemToReg=1 for LW.
  - pc_write=1, pc_src=00, next state FETCH.
- BRANCH:
  - alu_op=sub, pc_write=1.
  - pc_src=01 if taken (BEQ: zero=1; BNE: zero=0), else 00.
  - Next state FETCH.
- JUMP:
  - pc_write=1. pc_src=10 for J/JAL, 11 for JR.
  - JAL additionally asserts RegWrite=1 and link=1.
  - Next state FETCH.
- SYSCALL:
  - vreg==SYS_EXIT -> HALT, with no pc_write.
  - vreg==SYS_PRINT: print_req=1.
  - Any other value: illegal=1.
  - For both non-exit cases: pc_write=1, pc_src=00, next state FETCH.
- HALT: halted=1, all other outputs 0. Exits only via reset.
- Latency (instr_valid already high in FETCH):
  - R-type/ALU-immediate: 4 cycles.
  - LW: 4+MEM_WAIT.
  - SW: 3+MEM_WAIT.
  - Branch/jump/syscall: 3.
  - Illegal: 2.
- Exactly one pc_write pulse per retired or illegal instruction; none on halt.

Test Plan:
- Reset released, instr_valid held low 5 cycles, then ADD 0x00221820 -> fetch_req high for 6 cycles. Then alu_op=010 in EXEC; RegWrite=1 and RegDst=1 in WB; one pc_write with pc_src=00.
- LW 0x8C080004 with MEM_WAIT=3 -> MemRead high exactly 3 cycles, then WB with MemToReg=1 and RegWrite=1. Total 7 cycles from fetch to pc_write.
- BEQ 0x10000003: zero=1 -> pc_src=01; repeat with zero=0 -> pc_src=00; BNE 0x14000003 with zero=0 -> pc_src=01.
- JAL 0x0C000010 -> JUMP state with pc_src=10, RegWrite=1, link=1. JR 0x03E00008 -> pc_src=11, RegWrite=0.
- SYSCALL 0x0000000C with vreg=4 -> print_req one cycle, then fetch resumes. With vreg=10 -> halted=1 and stays high for 20 cycles with instr_valid=1; fetch_req=0. With vreg=7 -> illegal pulse. Opcode 0xFC000000 -> illegal pulse, then FETCH.
- rst_n pulled low mid-MEM of SW -> MemWrite drops asynchronously, no pc_write. After release: IDLE, then FETCH.
